// File: rtl/vend_pkg.sv
// Shared types and constants for the vending price engine.
//   vend_state_e        : transaction FSM states
//   PRICE_ITEMn         : factory price of item n
//   DEFAULT_PRICES_4X8  : the four factory prices packed with item 0 in the LSB slice
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } vend_state_e;

  localparam logic [7:0] PRICE_ITEM0 = 8'd5;
  localparam logic [7:0] PRICE_ITEM1 = 8'd7;
  localparam logic [7:0] PRICE_ITEM2 = 8'd10;
  localparam logic [7:0] PRICE_ITEM3 = 8'd0;

  localparam logic [31:0] DEFAULT_PRICES_4X8 =
    {PRICE_ITEM3, PRICE_ITEM2, PRICE_ITEM1, PRICE_ITEM0};

endpackage

// File: rtl/vend_price_table.sv
// Runtime-programmable price register file, 2**ITEM_W entries of PRICE_W bits.
//   clk, rst : clock, synchronous active-high reset (reloads DEFAULT_PRICES)
//   we       : write strobe; waddr/wdata give entry and new price
//   raddr    : read address; rdata is the stored price (asynchronous read,
//              so a same-cycle write is not yet visible)
module vend_price_table #(
  parameter int unsigned ITEM_W  = 2,
  parameter int unsigned PRICE_W = 8,
  parameter logic [(2**ITEM_W)*PRICE_W-1:0] DEFAULT_PRICES = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ITEM_W-1:0]  waddr,
  input  logic [PRICE_W-1:0] wdata,
  input  logic [ITEM_W-1:0]  raddr,
  output logic [PRICE_W-1:0] rdata
);

  localparam int unsigned NITEMS = 2**ITEM_W;

  logic [PRICE_W-1:0] mem [NITEMS];

  // Storage with reset-to-defaults and a single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NITEMS; i++) begin
        mem[i] <= DEFAULT_PRICES[i*PRICE_W +: PRICE_W];
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vend_price_engine.sv
// Vending transaction engine: select an item, collect coins, then vend with
// change, or refund on cancel / inactivity timeout.
//   cfg_we/cfg_addr/cfg_price : price table write port (any state)
//   sel_valid/sel_item        : item request, honoured only in IDLE (sel_ready)
//   coin_valid/coin_value     : one coin per cycle, honoured only in COLLECT (coin_ready)
//   cancel                    : abort, refunds accumulated credit
//   vend_valid/vend_item      : one-cycle dispense pulse
//   change_valid/change_amt   : one-cycle change or refund pulse
//   credit, price_out         : accumulated credit, latched price of active item
//   err_unpriced              : one-cycle pulse when a price-0 item is selected
// Every output is a flop; the next-state logic computes the next output values.
module vend_price_engine
  import vend_pkg::*;
#(
  parameter int unsigned ITEM_W   = 2,
  parameter int unsigned PRICE_W  = 8,
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [(2**ITEM_W)*PRICE_W-1:0] DEFAULT_PRICES =
    ((2**ITEM_W)*PRICE_W)'(DEFAULT_PRICES_4X8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [ITEM_W-1:0]   cfg_addr,
  input  logic [PRICE_W-1:0]  cfg_price,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel_item,
  output logic                sel_ready,
  input  logic                coin_valid,
  input  logic [PRICE_W-1:0]  coin_value,
  output logic                coin_ready,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [ITEM_W-1:0]   vend_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic [PRICE_W-1:0]  price_out,
  output logic                err_unpriced
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  vend_state_e         state, state_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
  logic [CREDIT_W-1:0] credit_nxt, credit_upd, change_amt_nxt;
  logic [CREDIT_W:0]   credit_sum;
  logic [PRICE_W-1:0]  price_rd, price_nxt;
  logic [ITEM_W-1:0]   item_nxt;
  logic                vend_nxt, change_valid_nxt, err_nxt, tmo_hit;

  vend_price_table #(
    .ITEM_W         (ITEM_W),
    .PRICE_W        (PRICE_W),
    .DEFAULT_PRICES (DEFAULT_PRICES)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_price),
    .raddr (sel_item),
    .rdata (price_rd)
  );

  // Next-state, accumulator, timeout and next-output logic
  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    price_nxt        = price_out;
    item_nxt         = vend_item;
    tmo_nxt          = tmo_cnt;
    vend_nxt         = 1'b0;
    change_valid_nxt = 1'b0;
    change_amt_nxt   = '0;
    err_nxt          = 1'b0;

    // Saturating add; the extra MSB catches the carry out
    credit_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
    if (!coin_valid)             credit_upd = credit;
    else if (credit_sum[CREDIT_W]) credit_upd = '1;
    else                         credit_upd = credit_sum[CREDIT_W-1:0];

    tmo_hit = (TIMEOUT != 0) && !coin_valid && (tmo_cnt == TMO_LAST);

    case (state)
      IDLE: begin
        if (sel_valid) begin
          if (price_rd == '0) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt  = COLLECT;
            item_nxt   = sel_item;
            price_nxt  = price_rd;
            credit_nxt = '0;
            tmo_nxt    = '0;
          end
        end
      end

      COLLECT: begin
        credit_nxt = credit_upd;
        tmo_nxt    = coin_valid ? '0 : tmo_cnt + TMO_W'(1);
        // Cancel outranks reaching the price; a same-cycle coin is still credited
        if (cancel || tmo_hit) begin
          state_nxt        = REFUND;
          change_amt_nxt   = credit_upd;
          change_valid_nxt = (credit_upd != '0);
        end else if (credit_upd >= CREDIT_W'(price_out)) begin
          state_nxt        = VEND;
          vend_nxt         = 1'b1;
          change_amt_nxt   = credit_upd - CREDIT_W'(price_out);
          change_valid_nxt = (change_amt_nxt != '0);
        end
      end

      VEND, REFUND: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end

      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      credit       <= '0;
      price_out    <= '0;
      vend_item    <= '0;
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      err_unpriced <= 1'b0;
      sel_ready    <= 1'b1;
      coin_ready   <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= tmo_nxt;
      credit       <= credit_nxt;
      price_out    <= price_nxt;
      vend_item    <= item_nxt;
      vend_valid   <= vend_nxt;
      change_valid <= change_valid_nxt;
      change_amt   <= change_amt_nxt;
      err_unpriced <= err_nxt;
      sel_ready    <= (state_nxt == IDLE);
      coin_ready   <= (state_nxt == COLLECT);
    end
  end

endmodule

// File: tb/tb_vend_price_engine.sv
// Directed plus randomized bench for vend_price_engine with a transaction-level
// reference model (price array, credit arithmetic, idle counting).
module tb_vend_price_engine;

  localparam int unsigned ITEM_W   = 2;
  localparam int unsigned PRICE_W  = 8;
  localparam int unsigned CREDIT_W = 8;
  localparam int unsigned TIMEOUT  = 8;
  localparam int          CMAX     = 2**CREDIT_W - 1;

  logic                clk = 1'b0;
  logic                rst, cfg_we, sel_valid, coin_valid, cancel;
  logic [ITEM_W-1:0]   cfg_addr, sel_item;
  logic [PRICE_W-1:0]  cfg_price, coin_value;
  logic                sel_ready, coin_ready, vend_valid, change_valid, err_unpriced;
  logic [ITEM_W-1:0]   vend_item;
  logic [CREDIT_W-1:0] change_amt, credit;
  logic [PRICE_W-1:0]  price_out;

  int n_cmp = 0;
  int n_mis = 0;
  int prices [4];

  always #5 clk = ~clk;

  vend_price_engine #(
    .ITEM_W   (ITEM_W),
    .PRICE_W  (PRICE_W),
    .CREDIT_W (CREDIT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_price    (cfg_price),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .sel_ready    (sel_ready),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .coin_ready   (coin_ready),
    .cancel       (cancel),
    .vend_valid   (vend_valid),
    .vend_item    (vend_item),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .credit       (credit),
    .price_out    (price_out),
    .err_unpriced (err_unpriced)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    cfg_we = 0; sel_valid = 0; coin_valid = 0; cancel = 0;
  endtask

  task automatic do_cfg(input int a, input int p);
    cfg_we = 1; cfg_addr = ITEM_W'(a); cfg_price = PRICE_W'(p);
    step();
    cfg_we = 0;
  endtask

  task automatic do_sel(input int it);
    sel_valid = 1; sel_item = ITEM_W'(it);
    step();
    sel_valid = 0;
  endtask

  task automatic do_coin(input int v, input bit c);
    coin_valid = 1; coin_value = PRICE_W'(v); cancel = c;
    step();
    coin_valid = 0; cancel = 0;
  endtask

  initial begin
    int n, it, r, a, p, mode, price_m, credit_m, idle, exp_amt;
    bit done, exp_vend, exp_chg, cv, cc;

    rst = 1; quiet();
    cfg_addr = '0; cfg_price = '0; sel_item = '0; coin_value = '0;
    prices = '{5, 7, 10, 0};
    step(); step();
    chk("rst_sel_ready", sel_ready, 1);
    chk("rst_coin_ready", coin_ready, 0);
    chk("rst_credit", credit, 0);
    chk("rst_price_out", price_out, 0);
    chk("rst_vend_valid", vend_valid, 0);
    chk("rst_change_valid", change_valid, 0);
    rst = 0;
    step();

    // Item 1 (price 7) paid with 5+5
    do_sel(1);
    chk("sel1_coin_ready", coin_ready, 1);
    chk("sel1_price", price_out, 7);
    do_coin(5, 0);
    chk("sel1_credit5", credit, 5);
    chk("sel1_novend", vend_valid, 0);
    do_coin(5, 0);
    chk("sel1_vend", vend_valid, 1);
    chk("sel1_item", vend_item, 1);
    chk("sel1_chg_v", change_valid, 1);
    chk("sel1_chg_amt", change_amt, 3);
    step();
    chk("sel1_idle", sel_ready, 1);
    chk("sel1_credit0", credit, 0);

    // Unpriced item 3
    do_sel(3);
    chk("err_pulse", err_unpriced, 1);
    chk("err_sel_ready", sel_ready, 1);
    chk("err_coin_ready", coin_ready, 0);
    chk("err_novend", vend_valid, 0);
    step();
    chk("err_one_cycle", err_unpriced, 0);

    // Reprogram item 2, then cancel together with a coin
    do_cfg(2, 12); prices[2] = 12;
    do_sel(2);
    chk("cx_price", price_out, 12);
    do_coin(10, 0);
    chk("cx_novend10", vend_valid, 0);
    do_coin(5, 1);
    chk("cx_chg_v", change_valid, 1);
    chk("cx_chg_amt", change_amt, 15);
    chk("cx_novend", vend_valid, 0);
    step();
    chk("cx_idle", sel_ready, 1);

    // Timeout: coin 3 then silence
    do_sel(0);
    coin_valid = 1; coin_value = 3;
    step();
    coin_valid = 0;
    n = 1;
    while (!change_valid && n < 30) begin
      step();
      n++;
    end
    chk("tmo_latency", n, TIMEOUT + 1);
    chk("tmo_amt", change_amt, 3);
    step();
    chk("tmo_idle", sel_ready, 1);

    // Price rewrite during COLLECT must not affect the active transaction
    do_cfg(2, 10); prices[2] = 10;
    do_sel(2);
    chk("rw_price10", price_out, 10);
    do_cfg(2, 1); prices[2] = 1;
    do_coin(5, 0);
    chk("rw_novend", vend_valid, 0);
    do_coin(5, 0);
    chk("rw_vend", vend_valid, 1);
    chk("rw_nochg", change_valid, 0);
    step();
    do_sel(2);
    chk("rw_price1", price_out, 1);
    do_coin(1, 0);
    chk("rw_vend1", vend_valid, 1);
    step();

    // Credit saturation
    do_cfg(1, 200); prices[1] = 200;
    do_sel(1);
    do_coin(100, 0);
    chk("sat_credit100", credit, 100);
    do_coin(255, 0);
    chk("sat_credit", credit, CMAX);
    chk("sat_vend", vend_valid, 1);
    chk("sat_chg_amt", change_amt, 55);
    step();

    // Reset mid-COLLECT: no refund, defaults restored
    do_sel(1);
    do_coin(50, 0);
    rst = 1;
    step();
    chk("mrst_nochg", change_valid, 0);
    chk("mrst_credit", credit, 0);
    chk("mrst_sel_ready", sel_ready, 1);
    chk("mrst_coin_ready", coin_ready, 0);
    rst = 0;
    prices = '{5, 7, 10, 0};
    do_sel(1);
    chk("mrst_default", price_out, 7);
    do_coin(0, 1);
    chk("mrst_cancel0", change_valid, 0);
    step();

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, 3); p = $urandom_range(0, 40);
        do_cfg(a, p); prices[a] = p;
      end
      it = $urandom_range(0, 3);
      do_sel(it);
      if (prices[it] == 0) begin
        chk("rnd_err", err_unpriced, 1);
        chk("rnd_err_ready", sel_ready, 1);
        continue;
      end
      price_m = prices[it];
      chk("rnd_price", price_out, price_m);
      chk("rnd_coin_ready", coin_ready, 1);
      mode = $urandom_range(0, 3);
      credit_m = 0; idle = 0; done = 0;
      for (int s = 0; s < 60 && !done; s++) begin
        r  = $urandom_range(0, 19);
        cv = (mode == 0) ? (r < 2) : (r < 12);
        cc = (r == 19);
        coin_valid = cv; coin_value = PRICE_W'($urandom_range(1, 20)); cancel = cc;
        sel_valid = (r == 15); sel_item = ITEM_W'($urandom_range(0, 3));
        cfg_we = (r == 16); cfg_addr = ITEM_W'($urandom_range(0, 3));
        cfg_price = PRICE_W'($urandom_range(0, 40));
        step();
        if (cfg_we) prices[cfg_addr] = int'(cfg_price);
        if (cv) begin
          credit_m = (credit_m + int'(coin_value) > CMAX) ? CMAX : credit_m + int'(coin_value);
          idle = 0;
        end else begin
          idle++;
        end
        exp_vend = 0; exp_chg = 0; exp_amt = 0;
        if (cc || idle == TIMEOUT) begin
          done = 1; exp_amt = credit_m; exp_chg = (credit_m != 0);
        end else if (credit_m >= price_m) begin
          done = 1; exp_vend = 1; exp_amt = credit_m - price_m; exp_chg = (exp_amt != 0);
        end
        chk("rnd_vend", vend_valid, exp_vend);
        chk("rnd_chg_v", change_valid, exp_chg);
        if (exp_chg) chk("rnd_chg_amt", change_amt, exp_amt);
        chk("rnd_credit", credit, credit_m);
        chk("rnd_item", vend_item, it);
      end
      quiet();
      if (!done) chk("rnd_txn_done", 0, 1);
      step();
      chk("rnd_back_idle", sel_ready, 1);
      chk("rnd_credit_clr", credit, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vend_price_engine.md
# vend_price_engine

Parametrised successor to the fixed 4-entry price lookup. It holds a runtime-programmable price table of 2**ITEM_W entries and runs one vending transaction at a time: select, collect coins, then vend with change, or refund on cancel or timeout. It sits between the front-panel/coin-acceptor logic and the dispense/change actuators.

## Interface
- ITEM_W, 2, item-select width; table depth NITEMS = 2**ITEM_W
- PRICE_W, 8, width of prices and coin values
- CREDIT_W, 8, credit accumulator and change width; must be >= PRICE_W
- TIMEOUT, 255, idle cycles allowed in COLLECT before auto-refund; 0 disables the timeout
- DEFAULT_PRICES, {0,10,7,5} packed NITEMS×PRICE_W with entry 0 in the LSB slice, table contents after reset
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  price-table write strobe
- cfg_addr  in  ITEM_W  table entry to write
- cfg_price  in  PRICE_W  new price
- sel_valid  in  1  item request
- sel_item  in  ITEM_W  requested item
- sel_ready  out  1  high only in IDLE
- coin_valid  in  1  one coin of coin_value this cycle
- coin_value  in  PRICE_W  coin denomination
- coin_ready  out  1  high only in COLLECT; coins while low are ignored
- cancel  in  1  abort the current transaction
- vend_valid  out  1  one-cycle dispense pulse
- vend_item  out  ITEM_W  item being dispensed, valid with vend_valid
- change_valid  out  1  one-cycle change/refund pulse
- change_amt  out  CREDIT_W  amount to return, valid with change_valid
- credit  out  CREDIT_W  current accumulated credit
- price_out  out  PRICE_W  latched price of the active item
- err_unpriced  out  1  one-cycle pulse: selected item has price 0

## Operation
- Reset: table loads DEFAULT_PRICES; state IDLE; credit, price_out, vend_item and the pulse outputs are 0; sel_ready=1, coin_ready=0.
- The table is writable in any state. A write never affects a transaction already in progress, because price_out is latched at selection.
- FSM states: IDLE, COLLECT, VEND, REFUND.
- IDLE, on sel_valid:
  - Price of sel_item == 0: pulse err_unpriced next cycle and stay in IDLE.
  - Otherwise: latch vend_item and price_out, clear credit, go to COLLECT.
  - cfg_we to the same entry in the same cycle: the pre-write price is latched.
- COLLECT:
  - coin_valid adds coin_value to credit, saturating at 2**CREDIT_W-1.
  - If the updated credit >= price_out, go to VEND.
  - cancel, or TIMEOUT consecutive cycles without coin_valid, goes to REFUND.
  - cancel together with a coin: the coin is credited first, then REFUND. cancel takes priority over reaching the price.
  - Every accepted coin reloads the timeout counter.
- VEND, one cycle:
  - vend_valid=1.
  - change_amt = credit - price_out; change_valid=1 only if that is nonzero.
  - Next state IDLE with credit cleared.
- REFUND, one cycle: change_amt = credit; change_valid=1 only if credit is nonzero; next state IDLE with credit cleared.
- sel_valid outside IDLE is ignored and is not queued.
- rst asserted mid-transaction discards the credit: no refund pulse, table returns to defaults.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- sel_valid accepted at cycle t: coin_ready=1 and price_out valid at t+1.
- Coin that completes payment at cycle t: vend_valid and change_valid at t+1, sel_ready=1 at t+2.
- cancel at t: change_valid at t+1, IDLE at t+2.
- Timeout: the last coin (or entry to COLLECT) at t gives REFUND at t+TIMEOUT+1.
- cfg write at t is visible to a selection made at t+1.
- Maximum throughput is one transaction per 3 cycles.

## Structure
- Package vend_pkg holds the state enum (IDLE, COLLECT, VEND, REFUND) and the default price constants 5, 7, 10, 0.
- Sub-module price_table: a parametrised NITEMS×PRICE_W register file with a synchronous write port, an asynchronous read port and reset to DEFAULT_PRICES. It replaces the fixed mux.
- The top level holds the FSM, the credit accumulator with saturation, and the timeout counter.

## Test plan
- Reset then sel_item=1 with coins 5,5: vend_valid, vend_item=1, change_amt=3, change_valid=1; credit returns to 0.
- sel_item=3 with its price 0: err_unpriced pulses, sel_ready stays 1, no vend.
- cfg write item2=12, then select 2 and insert coin 10 followed by cancel in the same cycle as a coin of 5: refund change_amt=15, no vend.
- Select 0, insert coin 3, then no activity with TIMEOUT=8: change_valid with change_amt=3 exactly 9 cycles after the coin.
- Select 2 (price 10), then write item2=1 mid-COLLECT: vend still requires 10; the next transaction uses 1.
- Coins of 255 with price_out 200 and CREDIT_W=8: credit saturates at 255, change_amt=55; rst mid-COLLECT clears everything with no change pulse.
